// File: rtl/approx_mul4_err_sweep.sv
// Exhaustive error sweep for a 4x4 approximate multiplier under test: drives all
// 256 operand pairs, compares each product to A*B and accumulates error statistics.
module approx_mul4_err_sweep #(
    parameter int PIPE_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [3:0]  mut_a,
    output logic [3:0]  mut_b,
    input  logic [7:0]  mut_r,
    output logic        busy,
    output logic        done,
    output logic [8:0]  err_cnt,
    output logic [15:0] sed,
    output logic [17:0] ser,
    output logic [7:0]  max_ed,
    output logic [3:0]  max_a,
    output logic [3:0]  max_b
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [7:0]  idx_reg;
    logic        running, start_ok, abort_ok, flush;
    logic        tag_v_in, tag_v;
    logic [7:0]  tag_i_in, tag_i;
    logic        samp_v_reg;
    logic [7:0]  samp_i_reg, samp_r_reg;
    logic [7:0]  exact;
    logic [8:0]  diff;
    logic [7:0]  abs_d;
    logic        acc_en;
    logic [8:0]  err_cnt_reg;
    logic [15:0] sed_reg;
    logic [17:0] ser_reg;
    logic [7:0]  max_ed_reg;
    logic [3:0]  max_a_reg, max_b_reg;

    assign running  = (state_reg == ST_SWEEP) || (state_reg == ST_DRAIN);
    assign start_ok = start && !running;
    assign abort_ok = abort && running;
    assign flush    = start_ok || abort_ok;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: if (start) state_next = ST_SWEEP;
            ST_SWEEP: begin
                if (abort)                  state_next = ST_IDLE;
                else if (idx_reg == 8'hFF)  state_next = ST_DRAIN;
            end
            default: begin
                if (abort)                                    state_next = ST_IDLE;
                else if (samp_v_reg && samp_i_reg == 8'hFF)   state_next = ST_DONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Index saturates at 255 so the MUT operands hold (15,15) after the sweep.
    always_ff @(posedge clk) begin
        if (rst || start_ok)
            idx_reg <= 8'd0;
        else if (state_reg == ST_SWEEP && !abort_ok && idx_reg != 8'hFF)
            idx_reg <= idx_reg + 8'd1;
    end

    assign mut_a    = idx_reg[7:4];
    assign mut_b    = idx_reg[3:0];
    assign tag_v_in = (state_reg == ST_SWEEP);
    assign tag_i_in = idx_reg;

    // Tag delay line matching the MUT latency, so each product meets its own index.
    generate
        if (PIPE_LAT == 0) begin : g_wire
            assign tag_v = tag_v_in;
            assign tag_i = tag_i_in;
        end else begin : g_pipe
            logic       pv_reg [PIPE_LAT];
            logic [7:0] pi_reg [PIPE_LAT];
            for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    always_ff @(posedge clk) begin
                        if (rst || flush) pv_reg[gi] <= 1'b0;
                        else              pv_reg[gi] <= tag_v_in;
                        pi_reg[gi] <= tag_i_in;
                    end
                end else begin : g_body
                    always_ff @(posedge clk) begin
                        if (rst || flush) pv_reg[gi] <= 1'b0;
                        else              pv_reg[gi] <= pv_reg[gi-1];
                        pi_reg[gi] <= pi_reg[gi-1];
                    end
                end
            end
            assign tag_v = pv_reg[PIPE_LAT-1];
            assign tag_i = pi_reg[PIPE_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || flush) samp_v_reg <= 1'b0;
        else              samp_v_reg <= tag_v;
    end

    always_ff @(posedge clk) begin
        samp_i_reg <= tag_i;
        samp_r_reg <= mut_r;
    end

    assign exact  = {4'd0, samp_i_reg[7:4]} * {4'd0, samp_i_reg[3:0]};
    assign diff   = {1'b0, samp_r_reg} - {1'b0, exact};
    assign abs_d  = diff[8] ? (~diff[7:0] + 8'd1) : diff[7:0];
    assign acc_en = samp_v_reg && running && !abort_ok;

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_cnt_reg <= '0;
            sed_reg     <= '0;
            ser_reg     <= '0;
            max_ed_reg  <= '0;
            max_a_reg   <= '0;
            max_b_reg   <= '0;
        end else if (acc_en) begin
            err_cnt_reg <= err_cnt_reg + {8'd0, (diff != 9'd0)};
            sed_reg     <= sed_reg + {8'd0, abs_d};
            ser_reg     <= ser_reg + {{9{diff[8]}}, diff};
            // Strict compare keeps the lowest index on a tie.
            if (abs_d > max_ed_reg) begin
                max_ed_reg <= abs_d;
                max_a_reg  <= samp_i_reg[7:4];
                max_b_reg  <= samp_i_reg[3:0];
            end
        end
    end

    assign busy    = running;
    assign done    = (state_reg == ST_DONE);
    assign err_cnt = err_cnt_reg;
    assign sed     = sed_reg;
    assign ser     = ser_reg;
    assign max_ed  = max_ed_reg;
    assign max_a   = max_a_reg;
    assign max_b   = max_b_reg;

endmodule

// File: tb/tb_approx_mul4_err_sweep.sv
// Bench for approx_mul4_err_sweep: a combinational MUT (latency 0) and a two-stage
// registered MUT (latency 2) swept side by side against a behavioural model.
module tb_approx_mul4_err_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort;

    logic [3:0]  mut_a0, mut_b0, max_a0, max_b0;
    logic [7:0]  mut_r0, max_ed0;
    logic        busy0, done0;
    logic [8:0]  err_cnt0;
    logic [15:0] sed0;
    logic [17:0] ser0;

    logic [3:0]  mut_a2, mut_b2, max_a2, max_b2;
    logic [7:0]  mut_r2, max_ed2;
    logic        busy2, done2;
    logic [8:0]  err_cnt2;
    logic [15:0] sed2;
    logic [17:0] ser2;

    approx_mul4_err_sweep #(.PIPE_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mut_a(mut_a0), .mut_b(mut_b0), .mut_r(mut_r0),
        .busy(busy0), .done(done0), .err_cnt(err_cnt0), .sed(sed0), .ser(ser0),
        .max_ed(max_ed0), .max_a(max_a0), .max_b(max_b0)
    );

    approx_mul4_err_sweep #(.PIPE_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mut_a(mut_a2), .mut_b(mut_b2), .mut_r(mut_r2),
        .busy(busy2), .done(done2), .err_cnt(err_cnt2), .sed(sed2), .ser(ser2),
        .max_ed(max_ed2), .max_a(max_a2), .max_b(max_b2)
    );

    // Multiplier stubs: 0 exact, 1 LSB dropped, 2 constant zero, 3 lookup table.
    int         mode = 0;
    logic [7:0] lut [256];

    function automatic logic [7:0] mut_model(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = {4'd0, a} * {4'd0, b};
        case (mode)
            0:       return p;
            1:       return p & 8'hFE;
            2:       return 8'd0;
            default: return lut[{a, b}];
        endcase
    endfunction

    always_comb mut_r0 = mut_model(mut_a0, mut_b0);

    logic [7:0] stub_r1, stub_r2;
    always @(posedge clk) begin
        stub_r1 <= mut_model(mut_a2, mut_b2);
        stub_r2 <= stub_r1;
    end
    assign mut_r2 = stub_r2;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Whole-sweep statistics straight from the definition.
    task automatic model_stats(output int c, output int s, output int sr,
                               output int mx, output int ma, output int mb);
        c = 0; s = 0; sr = 0; mx = 0; ma = 0; mb = 0;
        for (int i = 0; i < 256; i++) begin
            int a, b, d, ad;
            a  = i / 16;
            b  = i % 16;
            d  = int'(mut_model(4'(a), 4'(b))) - a * b;
            ad = (d < 0) ? -d : d;
            if (d != 0) c++;
            s  += ad;
            sr += d;
            if (ad > mx) begin mx = ad; ma = a; mb = b; end
        end
    endtask

    // Model state per instance: 0 reset, 1 started (n edges since start), 2 aborted.
    int phase [2];
    int n [2];
    int e_cnt [2], e_sed [2], e_ser [2], e_max [2], e_ma [2], e_mb [2];
    bit model_ok = 0;

    function automatic int lat_of(input int j);
        return (j == 0) ? 0 : 2;
    endfunction

    initial begin
        phase[0] = 0; phase[1] = 0; n[0] = 0; n[1] = 0;
    end

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            bit finished;
            finished = (phase[j] == 1) && (n[j] >= 257 + lat_of(j));
            if (rst) phase[j] = 0;
            else if (phase[j] == 1 && !finished) begin
                if (abort) phase[j] = 2;
                else       n[j]++;
            end else if (start) begin
                phase[j] = 1;
                n[j] = 0;
                model_stats(e_cnt[j], e_sed[j], e_ser[j], e_max[j], e_ma[j], e_mb[j]);
            end
        end
        model_ok = 1;
    end

    task automatic check_dut(input int j, input logic bz, input logic dn,
                             input logic [3:0] a_o, input logic [3:0] b_o,
                             input logic [8:0] ec, input logic [15:0] s,
                             input logic [17:0] sr, input logic [7:0] me,
                             input logic [3:0] ma, input logic [3:0] mb);
        string p;
        int ab;
        p  = $sformatf("lat%0d", lat_of(j));
        ab = int'({a_o, b_o});
        if (phase[j] == 0) begin
            chk({p, " reset busy"}, bz, 0);
            chk({p, " reset done"}, dn, 0);
            chk({p, " reset operands"}, ab, 0);
            chk({p, " reset err_cnt"}, ec, 0);
            chk({p, " reset sed"}, s, 0);
            chk({p, " reset ser"}, sr, 0);
            chk({p, " reset max_ed"}, me, 0);
            chk({p, " reset max_ab"}, int'({ma, mb}), 0);
        end else if (phase[j] == 2) begin
            chk({p, " aborted busy"}, bz, 0);
            chk({p, " aborted done"}, dn, 0);
        end else if (n[j] <= 256 + lat_of(j)) begin
            chk({p, " sweep busy"}, bz, 1);
            chk({p, " sweep done"}, dn, 0);
            chk({p, " sweep operands"}, ab, (n[j] > 255) ? 255 : n[j]);
        end else begin
            chk({p, " done busy"}, bz, 0);
            chk({p, " done flag"}, dn, 1);
            chk({p, " done operands"}, ab, 255);
            chk({p, " err_cnt"}, ec, e_cnt[j]);
            chk({p, " sed"}, s, e_sed[j]);
            chk({p, " ser"}, $signed(sr), e_ser[j]);
            chk({p, " max_ed"}, me, e_max[j]);
            chk({p, " max_a"}, ma, e_ma[j]);
            chk({p, " max_b"}, mb, e_mb[j]);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            check_dut(0, busy0, done0, mut_a0, mut_b0, err_cnt0, sed0, ser0, max_ed0, max_a0, max_b0);
            check_dut(1, busy2, done2, mut_a2, mut_b2, err_cnt2, sed2, ser2, max_ed2, max_a2, max_b2);
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!(done0 && done2) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (!(done0 && done2)) begin
            fails++;
            tests++;
            $display("FAIL done timeout: got done0=%0d done2=%0d, expected 1 1", done0, done2);
        end
    endtask

    task automatic expect_lit(input string name, input int c, input int s, input int sr,
                              input int mx, input int ma, input int mb);
        chk({name, " lat0 err_cnt"}, err_cnt0, c);
        chk({name, " lat0 sed"}, sed0, s);
        chk({name, " lat0 ser"}, $signed(ser0), sr);
        chk({name, " lat0 max"}, int'({max_ed0, max_a0, max_b0}), (mx << 8) | (ma << 4) | mb);
        chk({name, " lat2 err_cnt"}, err_cnt2, c);
        chk({name, " lat2 sed"}, sed2, s);
        chk({name, " lat2 ser"}, $signed(ser2), sr);
        chk({name, " lat2 max"}, int'({max_ed2, max_a2, max_b2}), (mx << 8) | (ma << 4) | mb);
    endtask

    task automatic fill_lut();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] p;
            p = 8'(i / 16) * 8'(i % 16);
            lut[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : p;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        mode = 0; pulse_start(); wait_done();
        $display("[TB] exact stub sweep finished");
        expect_lit("exact", 0, 0, 0, 0, 0, 0);

        mode = 1; pulse_start(); wait_done();
        $display("[TB] lsb-drop stub sweep finished");
        expect_lit("lsbdrop", 64, 64, -64, 1, 1, 1);

        mode = 2; pulse_start(); wait_done();
        $display("[TB] zero stub sweep finished");
        expect_lit("zero", 225, 14400, -14400, 225, 15, 15);

        // Start re-pulsed mid-sweep must be ignored.
        pulse_start();
        repeat (100) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done();
        $display("[TB] sweep with ignored restart finished");
        expect_lit("restart-ignored", 225, 14400, -14400, 225, 15, 15);

        pulse_start();
        repeat (50) @(negedge clk);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        repeat (4) @(negedge clk);
        $display("[TB] abort at idx 50 issued");

        pulse_start();
        repeat (200) @(negedge clk);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] reset at idx 200 issued");

        pulse_start(); wait_done();
        $display("[TB] fresh sweep after reset finished");
        expect_lit("after-reset", 225, 14400, -14400, 225, 15, 15);

        mode = 3;
        for (int r = 0; r < 3; r++) begin
            fill_lut();
            pulse_start(); wait_done();
            $display("[TB] random lut sweep %0d: err_cnt=%0d sed=%0d", r, err_cnt0, sed0);
            if (r == 0) begin
                // Restart from DONE with abort asserted too: start wins.
                @(negedge clk); start = 1'b1; abort = 1'b1;
                @(negedge clk); start = 1'b0; abort = 1'b0;
                wait_done();
                $display("[TB] random lut restart from done: err_cnt=%0d sed=%0d", err_cnt0, sed0);
            end
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/approx_mul4_err_sweep.md
# approx_mul4_err_sweep

Self-checking error-characterisation stage for the 4x4 LUT/CARRY4 approximate multipliers. It drives all 256 operand pairs into an externally instantiated multiplier under test (MUT) and consumes its 8-bit product. It compares each product against the exact product and accumulates error statistics (error count, sum of error distance, signed error sum, maximum error distance and its operand pair). It sits directly downstream of the multiplier, and the MUT's operand inputs are driven from this block.

## Interface
- `PIPE_LAT`, default 0: cycles between operands presented on `mut_a`/`mut_b` and the matching `mut_r` valid. 0 means a combinational MUT. Legal range 0..7.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin sweep; sampled in IDLE or DONE only.
- `abort` in 1: synchronous abandon of a running sweep.
- `mut_a` out 4: operand A to MUT.
- `mut_b` out 4: operand B to MUT.
- `mut_r` in 8: approximate product from MUT.
- `busy` out 1: high in SWEEP and DRAIN.
- `done` out 1: high in DONE; results valid.
- `err_cnt` out 9: pairs with `mut_r` ≠ A*B (0..256).
- `sed` out 16: Σ|mut_r − A*B|.
- `ser` out 18: signed Σ(mut_r − A*B), two's complement.
- `max_ed` out 8: max |mut_r − A*B|.
- `max_a` out 4: A of the first pair reaching `max_ed`.
- `max_b` out 4: B of the first pair reaching `max_ed`.

## Operation
- FSM states are IDLE, SWEEP, DRAIN and DONE. Reset enters IDLE.
- IDLE or DONE with `start`=1 leads to SWEEP.
  - Index counter is cleared to 0.
  - All statistics outputs are cleared.
- SWEEP: the 8-bit index `idx` is registered and drives `{mut_a, mut_b} = idx`, so A is the high nibble.
  - `idx` increments every cycle.
  - After the cycle that presents idx=255, the FSM goes to DRAIN.
- Tag pipeline: a PIPE_LAT-deep shift register carries a valid bit and the 8-bit index alongside the MUT latency. For PIPE_LAT=0 it is a direct wire.
- Compare: when a tagged sample is valid, the block forms exact = A*B (8-bit unsigned) and d = mut_r − exact (9-bit signed).
  - `err_cnt` += (d≠0).
  - `sed` += |d|.
  - `ser` += d (sign-extended).
  - If |d| > `max_ed`, update `max_ed`, `max_a` and `max_b`. This is a strict compare, so on a tie the lowest index is kept.
- DRAIN: lasts until the tag for idx=255 has been accumulated, then the FSM goes to DONE.
- DONE: results are held stable, and `done`=1 until the next `start`.
- `start` in SWEEP or DRAIN is ignored.
- `abort` in SWEEP or DRAIN leads to IDLE.
  - The tag pipeline is flushed.
  - Statistics keep partial values, but `done` stays 0.
  - `abort` in IDLE or DONE has no effect.
  - `start` and `abort` together in DONE: `start` wins.
- Width guarantees:
  - The maximum |d| for any 4x4 product is 255, which fits 8 bits.
  - `sed` ≤ 256·255, which fits 16 bits.
  - `ser` ∈ [−57600, 65280], which fits 18 bits signed.
- No saturation logic is required.

## Timing
- Reset values:
  - FSM = IDLE.
  - `busy`, `done`, `mut_a`, `mut_b`, `err_cnt`, `sed`, `ser`, `max_ed`, `max_a` and `max_b` are all 0.
  - Tag valids are 0.
- Counting from the edge k at which `start` is sampled:
  - Pair i appears on `mut_a`/`mut_b` during cycle k+1+i.
  - Its `mut_r` is sampled at the end of cycle k+1+i+PIPE_LAT.
  - `done` rises in cycle k+258+PIPE_LAT.
- `busy` is high from cycle k+1 through the last accumulating cycle. It is never high in the same cycle as `done`.
- `mut_a`/`mut_b` hold their last value (15,15) after the sweep until the next start or reset.
- Reset mid-sweep takes priority over all other inputs and returns every output to its reset value on the next edge.

## Test plan
- Exact stub `mut_r`=A*B, PIPE_LAT=0, pulse `start`.
  - Expect `done` 258 cycles later.
  - Expect `err_cnt`=0, `sed`=0, `ser`=0, `max_ed`=0, `max_a`/`max_b`=0/0.
- Stub `mut_r`=(A*B)&8'hFE.
  - Expect `err_cnt`=64, `sed`=64, `ser`=−64, `max_ed`=1, `max_a`/`max_b`=1/1.
- Stub `mut_r`=0.
  - Expect `err_cnt`=225, `sed`=14400, `ser`=−14400, `max_ed`=225, `max_a`/`max_b`=15/15.
- Registered stub with PIPE_LAT=2, `mut_r`=0.
  - Expect the same results as the previous case.
  - Expect `done` exactly 260 cycles after start.
  - Expect no off-by-one in the tag alignment.
- Mid-operation events:
  - `start` re-pulsed at idx=100: ignored, results unchanged.
  - `abort` at idx=50: IDLE next cycle, `busy`=0, `done`=0.
  - `rst` at idx=200: all outputs 0.
  - A fresh `start` then gives the full correct results.
- Real LUT-based 4x4 approximate multiplier as MUT.
  - Sweep results must match the golden error statistics from the software model.
  - Restart from DONE must reproduce identical values.
